// File: rtl/fifo_fill_sequencer.sv
// Burst sequencer: steps an LFSR once per word, waits for its strobe and pushes
// the captured word into a FIFO, with abort, stall-on-full and strobe timeout.
module fifo_fill_sequencer #(
  parameter int DATA_WIDTH  = 4,
  parameter int COUNT_WIDTH = 5,
  parameter int TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] burst_len,
  input  logic                   abort,
  input  logic                   lfsr_strobe,
  input  logic [DATA_WIDTH-1:0]  lfsr_data,
  input  logic                   fifo_full,
  output logic                   lfsr_enable,
  output logic                   fifo_push,
  output logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  output logic [COUNT_WIDTH-1:0] pushed_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENABLE,
    S_WAIT,
    S_PUSH,
    S_DONE
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t                 state_reg;
  logic [COUNT_WIDTH-1:0] len_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic [COUNT_WIDTH-1:0] count_next;
  logic [DATA_WIDTH-1:0]  hold_reg;
  logic [7:0]             timer_reg;
  logic                   terr_reg;

  assign count_next = count_reg + COUNT_WIDTH'(1);

  // Strobes are masked while reset is held so nothing leaks out of a stale state.
  assign lfsr_enable  = (state_reg == S_ENABLE) && !reset;
  assign fifo_push    = (state_reg == S_PUSH) && !fifo_full && !abort && !reset;
  assign busy         = (state_reg != S_IDLE) && !reset;
  assign done         = (state_reg == S_DONE) && !reset;
  assign fifo_data    = hold_reg;
  assign timeout_err  = terr_reg;
  assign pushed_count = count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      len_reg   <= '0;
      count_reg <= '0;
      hold_reg  <= '0;
      timer_reg <= '0;
      terr_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (burst_len != '0) begin
              len_reg   <= burst_len;
              count_reg <= '0;
              terr_reg  <= 1'b0;
              state_reg <= S_ENABLE;
            end else begin
              state_reg <= S_DONE;
            end
          end
        end
        S_ENABLE: begin
          timer_reg <= '0;
          state_reg <= abort ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (abort) begin
            state_reg <= S_DONE;
          end else if (lfsr_strobe) begin
            hold_reg  <= lfsr_data;
            state_reg <= S_PUSH;
          end else if (timer_reg == TIMER_LAST) begin
            terr_reg  <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            timer_reg <= timer_reg + 8'd1;
          end
        end
        S_PUSH: begin
          // A full FIFO simply parks us here; only abort or reset can leave.
          if (abort) begin
            state_reg <= S_DONE;
          end else if (!fifo_full) begin
            count_reg <= count_next;
            state_reg <= (count_next == len_reg) ? S_DONE : S_ENABLE;
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_fill_sequencer.sv
// Bench for fifo_fill_sequencer: cycle vector table, hand-written timeout and
// reset sequences, then randomized bursts scored against a transaction model.
module tb_fifo_fill_sequencer;

  localparam int DW = 4;
  localparam int CW = 5;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset, start, abort, lfsr_strobe, fifo_full;
  logic [CW-1:0] burst_len;
  logic [DW-1:0] lfsr_data;
  logic          lfsr_enable, fifo_push, busy, done, timeout_err;
  logic [DW-1:0] fifo_data;
  logic [CW-1:0] pushed_count;

  int total = 0;
  int bad   = 0;

  fifo_fill_sequencer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .burst_len(burst_len), .abort(abort),
    .lfsr_strobe(lfsr_strobe), .lfsr_data(lfsr_data), .fifo_full(fifo_full),
    .lfsr_enable(lfsr_enable), .fifo_push(fifo_push), .fifo_data(fifo_data),
    .busy(busy), .done(done), .timeout_err(timeout_err), .pushed_count(pushed_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, st, ab, sb, fl;
    logic [CW-1:0] len;
    logic [DW-1:0] sd;
    logic          en, push, bsy, dn, terr;
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vec[23];

  function automatic vec_t mk(logic rst, logic st, int len, logic ab, logic sb, int sd, logic fl,
                              logic en, logic push, int data, logic bsy, logic dn, int cnt);
    vec_t v;
    v.rst = rst; v.st = st; v.len = CW'(len); v.ab = ab; v.sb = sb; v.sd = DW'(sd); v.fl = fl;
    v.en = en; v.push = push; v.data = DW'(data); v.bsy = bsy; v.dn = dn; v.terr = 1'b0;
    v.cnt = CW'(cnt);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random-burst scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] want;
  int n_push, n_en, n_strobe, wcnt, k, exp_len;
  bit waiting, finished, exp_timeout;
  int t_en, t_done, en_n;
  logic terr_at_done;
  logic [CW-1:0] cnt_at_done;

  initial begin
    //         rst st len ab sb sd  fl | en pu data bsy dn cnt
    vec[0]  = mk(1, 0, 0, 0, 0, 0,   0,  0, 0, 0,   0, 0, 0);
    vec[1]  = mk(0, 1, 0, 0, 0, 0,   0,  0, 0, 0,   0, 0, 0);  // zero-length burst
    vec[2]  = mk(0, 0, 0, 1, 0, 0,   0,  0, 0, 0,   1, 1, 0);  // abort in DONE is harmless
    vec[3]  = mk(0, 1, 2, 0, 0, 0,   0,  0, 0, 0,   0, 0, 0);
    vec[4]  = mk(0, 1, 7, 0, 0, 0,   0,  1, 0, 0,   1, 0, 0);  // start while busy ignored
    vec[5]  = mk(0, 0, 0, 0, 0, 0,   0,  0, 0, 0,   1, 0, 0);
    vec[6]  = mk(0, 0, 0, 0, 1, 'hA, 0,  0, 0, 0,   1, 0, 0);
    vec[7]  = mk(0, 0, 0, 0, 0, 0,   1,  0, 0, 'hA, 1, 0, 0);  // full stall
    vec[8]  = mk(0, 0, 0, 0, 1, 3,   1,  0, 0, 'hA, 1, 0, 0);  // stray strobe in PUSH
    vec[9]  = mk(0, 0, 0, 0, 0, 0,   0,  0, 1, 'hA, 1, 0, 0);
    vec[10] = mk(0, 0, 0, 0, 0, 0,   0,  1, 0, 'hA, 1, 0, 1);
    vec[11] = mk(0, 0, 0, 0, 1, 5,   0,  0, 0, 'hA, 1, 0, 1);
    vec[12] = mk(0, 0, 0, 0, 0, 0,   0,  0, 1, 5,   1, 0, 1);
    vec[13] = mk(0, 0, 0, 0, 0, 0,   0,  0, 0, 5,   1, 1, 2);
    vec[14] = mk(0, 1, 3, 0, 0, 0,   0,  0, 0, 5,   0, 0, 2);  // back-to-back start
    vec[15] = mk(0, 0, 0, 1, 0, 0,   0,  1, 0, 5,   1, 0, 0);  // abort in ENABLE
    vec[16] = mk(0, 0, 0, 0, 0, 0,   0,  0, 0, 5,   1, 1, 0);
    vec[17] = mk(0, 1, 2, 0, 0, 0,   0,  0, 0, 5,   0, 0, 0);
    vec[18] = mk(0, 0, 0, 0, 0, 0,   0,  1, 0, 5,   1, 0, 0);
    vec[19] = mk(0, 0, 0, 0, 1, 'hC, 0,  0, 0, 5,   1, 0, 0);
    vec[20] = mk(0, 0, 0, 1, 0, 0,   0,  0, 0, 'hC, 1, 0, 0);  // abort beats push
    vec[21] = mk(0, 0, 0, 0, 0, 0,   0,  0, 0, 'hC, 1, 1, 0);
    vec[22] = mk(0, 0, 0, 0, 0, 0,   0,  0, 0, 'hC, 0, 0, 0);

    reset = 1; start = 0; burst_len = 0; abort = 0; lfsr_strobe = 0; lfsr_data = 0; fifo_full = 0;
    tick(); tick();

    for (int i = 0; i < 23; i++) begin
      reset = vec[i].rst; start = vec[i].st; burst_len = vec[i].len; abort = vec[i].ab;
      lfsr_strobe = vec[i].sb; lfsr_data = vec[i].sd; fifo_full = vec[i].fl;
      #1;
      chk("vec_en", i, lfsr_enable, vec[i].en);
      chk("vec_push", i, fifo_push, vec[i].push);
      chk("vec_data", i, fifo_data, vec[i].data);
      chk("vec_busy", i, busy, vec[i].bsy);
      chk("vec_done", i, done, vec[i].dn);
      chk("vec_terr", i, timeout_err, vec[i].terr);
      chk("vec_cnt", i, pushed_count, vec[i].cnt);
      tick();
    end
    reset = 0; start = 0; abort = 0; lfsr_strobe = 0; fifo_full = 0;

    // Strobe never arrives: one enable, DONE 15 WAIT cycles later.
    start = 1; burst_len = 4; tick(); start = 0;
    t_en = -1; t_done = -1; en_n = 0; terr_at_done = 0; cnt_at_done = '1;
    for (int c = 0; c < 100 && t_done < 0; c++) begin
      #1;
      if (lfsr_enable) begin en_n++; if (t_en < 0) t_en = c; end
      if (done) begin t_done = c; terr_at_done = timeout_err; cnt_at_done = pushed_count; end
      tick();
    end
    chk("to_en_cycle", 0, t_en, 0);
    chk("to_done_cycle", 0, t_done, TO + 1);
    chk("to_en_count", 0, en_n, 1);
    chk("to_terr", 0, terr_at_done, 1);
    chk("to_cnt", 0, cnt_at_done, 0);
    #1 chk("to_terr_sticky", 0, timeout_err, 1);
    start = 1; burst_len = 1; tick(); start = 0;
    #1 chk("to_terr_clear", 0, timeout_err, 0);
    abort = 1; tick(); abort = 0; tick(); tick();

    // Reset while waiting for the strobe of a 4-word burst.
    start = 1; burst_len = 4; tick(); start = 0;
    tick(); tick();
    reset = 1; start = 1; abort = 1;
    #1;
    chk("rst_busy_during", 0, busy, 0);
    chk("rst_en_during", 0, lfsr_enable, 0);
    chk("rst_done_during", 0, done, 0);
    tick();
    reset = 0; start = 0; abort = 0;
    #1;
    chk("rst_busy_after", 0, busy, 0);
    chk("rst_done_after", 0, done, 0);
    chk("rst_data_after", 0, fifo_data, 0);
    chk("rst_cnt_after", 0, pushed_count, 0);
    chk("rst_terr_after", 0, timeout_err, 0);
    start = 1; burst_len = 1; tick(); start = 0;
    #1 chk("rst_restart_en", 0, lfsr_enable, 1);
    abort = 1; tick(); abort = 0; tick(); tick();

    // Randomized bursts: each enable is answered after k strobe-free cycles.
    for (int b = 0; b < 40; b++) begin
      exp_q.delete();
      n_push = 0; n_en = 0; n_strobe = 0; wcnt = 0; k = 0;
      waiting = 0; finished = 0; exp_timeout = 0;
      exp_len = $urandom_range(1, 6);
      cnt_at_done = '1; terr_at_done = 0;
      for (int c = 0; c < 2000 && !finished; c++) begin
        if (c == 0) begin
          start = 1; burst_len = CW'(exp_len);
        end else begin
          start = ($urandom_range(0, 9) == 0); burst_len = CW'($urandom);
        end
        fifo_full = ($urandom_range(0, 3) == 0);
        lfsr_strobe = 0; lfsr_data = DW'($urandom);
        if (waiting) begin
          if (wcnt == k && k < TO) begin
            lfsr_strobe = 1; exp_q.push_back(lfsr_data); n_strobe++; waiting = 0;
          end
          wcnt++;
        end else if (c > 0 && $urandom_range(0, 4) == 0) begin
          lfsr_strobe = 1;
        end
        #1;
        if (lfsr_enable) begin
          n_en++; waiting = 1; wcnt = 0;
          case ($urandom_range(0, 9))
            0:       k = TO - 1;
            1:       k = TO;
            default: k = $urandom_range(0, 3);
          endcase
          if (k >= TO) exp_timeout = 1;
        end
        if (fifo_push) begin
          n_push++;
          want = (exp_q.size() > 0) ? exp_q.pop_front() : ~fifo_data;
          chk("rnd_push_data", b, fifo_data, want);
        end
        if (done) begin
          finished = 1; cnt_at_done = pushed_count; terr_at_done = timeout_err;
        end
        tick();
      end
      start = 0; lfsr_strobe = 0; fifo_full = 0;
      chk("rnd_finished", b, finished, 1);
      chk("rnd_terr", b, terr_at_done, exp_timeout);
      chk("rnd_pushes", b, n_push, exp_timeout ? n_strobe : exp_len);
      chk("rnd_enables", b, n_en, exp_timeout ? n_strobe + 1 : exp_len);
      chk("rnd_cnt", b, cnt_at_done, n_push);
      chk("rnd_leftover", b, exp_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
